// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - decode-side bundle for the multiply/divide unit and its HI/LO registers
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             mf_req;
    logic             mt_we;
    logic             hl_sel;
    logic [WIDTH-1:0] mt_data;
    logic [WIDTH-1:0] mf_data;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Decode stage drives requests and observes results
    modport master (
        output start, op, operand_a, operand_b, mf_req, mt_we, hl_sel, mt_data,
        input  mf_data, busy, done, stall, hi, lo
    );

    // The unit itself
    modport slave (
        input  start, op, operand_a, operand_b, mf_req, mt_we, hl_sel, mt_data,
        output mf_data, busy, done, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic                clock,
    input logic                reset,
    muldiv_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    // Multiply: addend = |a|, acc_lo starts as |b| (multiplier shifted out LSB first).
    // Divide: addend = |b| (divisor), acc_lo starts as |a| and collects the quotient.
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             neg_lo;
    logic             neg_hi;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    // Operand magnitudes and one iteration of the shift-add / restoring-subtract step
    always_comb begin
        is_div   = op_q[1];
        sign_a   = ~op_q[0] & a_q[WIDTH-1];
        sign_b   = ~op_q[0] & b_q[WIDTH-1];
        abs_a    = sign_a ? (~a_q + 1'b1) : a_q;
        abs_b    = sign_b ? (~b_q + 1'b1) : b_q;
        add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, addend} : '0);
        shifted  = {acc_hi, acc_lo[WIDTH-1]};
        diff     = shifted - {1'b0, addend};
        prod     = {acc_hi, acc_lo};
        prod_neg = ~prod + 1'b1;
    end

    // Sequencer: operand capture, iteration, sign fix-up and HI/LO ownership
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            addend <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        a_q    <= bus.operand_a;
                        b_q    <= bus.operand_b;
                        busy_q <= 1'b1;
                        state  <= PREP;
                    end else if (bus.mt_we) begin
                        if (bus.hl_sel) hi_q <= bus.mt_data;
                        else            lo_q <= bus.mt_data;
                    end
                end
                PREP: begin
                    addend <= is_div ? abs_b : abs_a;
                    acc_lo <= is_div ? abs_a : abs_b;
                    acc_hi <= '0;
                    neg_lo <= sign_a ^ sign_b;
                    neg_hi <= is_div & sign_a;
                    count  <= CNT_W'(WIDTH - 1);
                    state  <= RUN;
                end
                RUN: begin
                    if (is_div) begin
                        if (!diff[WIDTH]) begin
                            acc_hi <= diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= shifted[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {add_sum, acc_lo[WIDTH-1:1]};
                    end
                    count <= count - 1'b1;
                    if (count == '0) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        // A zero divisor returns all-ones quotient and the raw dividend
                        if (b_q == '0) begin
                            lo_q <= '1;
                            hi_q <= a_q;
                        end else begin
                            lo_q <= neg_lo ? (~acc_lo + 1'b1) : acc_lo;
                            hi_q <= neg_hi ? (~acc_hi + 1'b1) : acc_hi;
                        end
                    end else begin
                        {hi_q, lo_q} <= neg_lo ? prod_neg : prod;
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.mf_data = bus.hl_sel ? hi_q : lo_q;
    assign bus.stall   = (bus.mf_req | bus.mt_we) & busy_q;
endmodule
